// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: front end of the 8-bit pipeline.
// Owns the program counter, the IF/ID pipeline register and the tracker
// that tags the immediate byte of 2-byte instructions.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_data_F        byte read from instruction memory at pc_F
//   is_2byte_op_F      predecode of imem_data_F (opcode takes an immediate)
//   stall_F, stall_D   active-low enables for the PC and the IF/ID register
//   flush_D            load a bubble into IF/ID
//   redirect_valid/pc  PC redirect from branch or return
//   pc_F               instruction memory address
//   instr_D, pc_next_D IF/ID byte and its address plus one
//   is_2byte_D         slot holds an immediate byte
//   nothing_here_d     slot is a bubble
module fetch_decode_stage #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] imem_data_F,
  input  logic       is_2byte_op_F,
  input  logic       stall_F,
  input  logic       stall_D,
  input  logic       flush_D,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  output logic [7:0] pc_F,
  output logic [7:0] instr_D,
  output logic [7:0] pc_next_D,
  output logic       is_2byte_D,
  output logic       nothing_here_d
);

  localparam int unsigned W = 8;

  typedef enum logic [1:0] {
    RST_VEC = 2'd0,
    OP      = 2'd1,
    IMM     = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [W-1:0]   instr_q, instr_d;
  logic [W-1:0]   pc_next_q, pc_next_d;
  logic           is_2byte_q, is_2byte_d;
  logic           nothing_q, nothing_d;
  logic [W-1:0]   pc_inc;

  // Modulo-256 increment shared by the PC and the return address.
  assign pc_inc = pc_q + W'(1);

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_VEC;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_next_q  <= '0;
      is_2byte_q <= 1'b0;
      nothing_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_next_q  <= pc_next_d;
      is_2byte_q <= is_2byte_d;
      nothing_q  <= nothing_d;
    end
  end

  // Next state and next PC. A stalled IMM stays IMM so the held immediate
  // is re-fetched with the right tag.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      RST_VEC: begin
        pc_d    = imem_data_F;
        state_d = OP;
      end
      default: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = OP;
        end else if (stall_F) begin
          pc_d    = pc_inc;
          state_d = (state_q == OP && is_2byte_op_F) ? IMM : OP;
        end
      end
    endcase
  end

  // IF/ID next values; evaluated independently of the PC decision.
  // A bubble only rewrites the tags, the data fields keep their contents.
  always_comb begin
    instr_d    = instr_q;
    pc_next_d  = pc_next_q;
    is_2byte_d = is_2byte_q;
    nothing_d  = nothing_q;
    if (state_q != RST_VEC) begin
      if (redirect_valid || flush_D) begin
        nothing_d  = 1'b1;
        is_2byte_d = 1'b0;
      end else if (!stall_D) begin
        // hold all fields
      end else if (!stall_F) begin
        // fetched byte is not consumed this cycle
        nothing_d  = 1'b1;
        is_2byte_d = 1'b0;
      end else begin
        instr_d    = imem_data_F;
        pc_next_d  = pc_inc;
        nothing_d  = 1'b0;
        is_2byte_d = (state_q == IMM);
      end
    end
  end

  assign pc_F           = pc_q;
  assign instr_D        = instr_q;
  assign pc_next_D      = pc_next_q;
  assign is_2byte_D     = is_2byte_q;
  assign nothing_here_d = nothing_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Testbench for fetch_decode_stage: table-driven vectors plus hand-written
// sequences for asynchronous reset in the IMM state.
module tb_fetch_decode_stage;

  logic       clk;
  logic       rst_n;
  logic [7:0] imem_data_F;
  logic       is_2byte_op_F;
  logic       stall_F;
  logic       stall_D;
  logic       flush_D;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [7:0] pc_F;
  logic [7:0] instr_D;
  logic [7:0] pc_next_D;
  logic       is_2byte_D;
  logic       nothing_here_d;

  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;

  fetch_decode_stage #(.RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_data_F   (imem_data_F),
    .is_2byte_op_F (is_2byte_op_F),
    .stall_F       (stall_F),
    .stall_D       (stall_D),
    .flush_D       (flush_D),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc_F          (pc_F),
    .instr_D       (instr_D),
    .pc_next_D     (pc_next_D),
    .is_2byte_D    (is_2byte_D),
    .nothing_here_d(nothing_here_d)
  );

  // Combinational instruction memory; opcodes with top bits 11 take an immediate.
  assign imem_data_F   = mem[pc_F];
  assign is_2byte_op_F = (imem_data_F[7:6] == 2'b11);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sf, sd, fl, rv;
    logic [7:0] rpc;
    logic [7:0] pc, ins, pcn;
    logic       b2, nh;
    logic       cd;     // compare instr_D / pc_next_D too
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [3:0] ctl, input logic [7:0] rpc,
                              input logic [7:0] pc, input logic [7:0] ins,
                              input logic [7:0] pcn, input logic b2,
                              input logic nh, input logic cd);
    vec_t v;
    v.sf = ctl[3]; v.sd = ctl[2]; v.fl = ctl[1]; v.rv = ctl[0];
    v.rpc = rpc; v.pc = pc; v.ins = ins; v.pcn = pcn;
    v.b2 = b2; v.nh = nh; v.cd = cd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sf, input logic sd, input logic fl,
                       input logic rv, input logic [7:0] rpc);
    stall_F = sf; stall_D = sd; flush_D = fl; redirect_valid = rv; redirect_pc = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[8'h00] = 8'h10;
    mem[8'h10] = 8'h21; mem[8'h11] = 8'hC5; mem[8'h12] = 8'h5A;
    mem[8'h13] = 8'h22; mem[8'h14] = 8'hC7; mem[8'h15] = 8'h77;
    mem[8'h40] = 8'h31; mem[8'h41] = 8'h32;
    mem[8'h33] = 8'h34; mem[8'h34] = 8'h35; mem[8'h35] = 8'h24;
    mem[8'h36] = 8'h25; mem[8'h37] = 8'h26;
    mem[8'hFE] = 8'h27; mem[8'hFF] = 8'h28;

    // ctl = {stall_F, stall_D, flush_D, redirect_valid}; expected values after the edge
    vecs[0]  = mk(4'b1100, 8'h00, 8'h10, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1); // reset vector
    vecs[1]  = mk(4'b1100, 8'h00, 8'h11, 8'h21, 8'h11, 1'b0, 1'b0, 1'b1); // first instr
    vecs[2]  = mk(4'b1100, 8'h00, 8'h12, 8'hC5, 8'h12, 1'b0, 1'b0, 1'b1); // 2-byte op -> IMM
    vecs[3]  = mk(4'b0000, 8'h00, 8'h12, 8'hC5, 8'h12, 1'b0, 1'b0, 1'b1); // load-use stall
    vecs[4]  = mk(4'b0000, 8'h00, 8'h12, 8'hC5, 8'h12, 1'b0, 1'b0, 1'b1);
    vecs[5]  = mk(4'b1100, 8'h00, 8'h13, 8'h5A, 8'h13, 1'b1, 1'b0, 1'b1); // immediate tagged
    vecs[6]  = mk(4'b1100, 8'h00, 8'h14, 8'h22, 8'h14, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(4'b1100, 8'h00, 8'h15, 8'hC7, 8'h15, 1'b0, 1'b0, 1'b1); // -> IMM
    vecs[8]  = mk(4'b1111, 8'h40, 8'h40, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); // redirect in IMM
    vecs[9]  = mk(4'b1100, 8'h00, 8'h41, 8'h31, 8'h41, 1'b0, 1'b0, 1'b1); // target as opcode
    vecs[10] = mk(4'b0110, 8'h00, 8'h41, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); // RET stall x3
    vecs[11] = mk(4'b0110, 8'h00, 8'h41, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    vecs[12] = mk(4'b0110, 8'h00, 8'h41, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    vecs[13] = mk(4'b0111, 8'h33, 8'h33, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); // return redirect
    vecs[14] = mk(4'b1100, 8'h00, 8'h34, 8'h34, 8'h34, 1'b0, 1'b0, 1'b1);
    vecs[15] = mk(4'b0100, 8'h00, 8'h34, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); // fetch stall -> bubble
    vecs[16] = mk(4'b1100, 8'h00, 8'h35, 8'h35, 8'h35, 1'b0, 1'b0, 1'b1);
    vecs[17] = mk(4'b1000, 8'h00, 8'h36, 8'h35, 8'h35, 1'b0, 1'b0, 1'b1); // PC moves, IF/ID holds
    vecs[18] = mk(4'b1110, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); // flush, PC advances
    vecs[19] = mk(4'b1100, 8'h00, 8'h38, 8'h26, 8'h38, 1'b0, 1'b0, 1'b1);
    vecs[20] = mk(4'b1101, 8'hFE, 8'hFE, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    vecs[21] = mk(4'b1100, 8'h00, 8'hFF, 8'h27, 8'hFF, 1'b0, 1'b0, 1'b1);
    vecs[22] = mk(4'b1100, 8'h00, 8'h00, 8'h28, 8'h00, 1'b0, 1'b0, 1'b1); // wrap

    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    #12;
    chk("rst_pc", pc_F, 8'h00);
    chk("rst_instr", instr_D, 8'h00);
    chk("rst_pcn", pc_next_D, 8'h00);
    chk("rst_b2", 8'(is_2byte_D), 8'h00);
    chk("rst_nh", 8'(nothing_here_d), 8'h01);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].rv, vecs[i].rpc);
      step();
      chk($sformatf("v%0d_pc", i), pc_F, vecs[i].pc);
      chk($sformatf("v%0d_b2", i), 8'(is_2byte_D), 8'(vecs[i].b2));
      chk($sformatf("v%0d_nh", i), 8'(nothing_here_d), 8'(vecs[i].nh));
      if (vecs[i].cd) begin
        chk($sformatf("v%0d_instr", i), instr_D, vecs[i].ins);
        chk($sformatf("v%0d_pcn", i), pc_next_D, vecs[i].pcn);
      end
    end

    // Enter IMM, then assert reset mid-cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h11);
    step();
    chk("imm_redir_pc", pc_F, 8'h11);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    chk("imm_pc", pc_F, 8'h12);
    chk("imm_instr", instr_D, 8'hC5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_F, 8'h00);
    chk("arst_nh", 8'(nothing_here_d), 8'h01);
    chk("arst_instr", instr_D, 8'h00);
    chk("arst_b2", 8'(is_2byte_D), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rerst_vec_pc", pc_F, 8'h10);
    chk("rerst_vec_nh", 8'(nothing_here_d), 8'h01);
    step();
    chk("rerst_pc", pc_F, 8'h11);
    chk("rerst_instr", instr_D, 8'h21);
    chk("rerst_b2", 8'(is_2byte_D), 8'h00);
    chk("rerst_nh", 8'(nothing_here_d), 8'h00);
    chk("rerst_pcn", pc_next_D, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
